// File: rtl/seven_segment_capture.sv
// rtl/seven_segment_capture.sv - decodes the multiplexed active-low 7-seg bus back into per-digit BCD
// Optional: SEG_CAPTURE_CHANGE_ONLY_EN suppresses the update pulse when a commit does not change the digit.
module seven_segment_capture #(
    parameter int NUM_DIGITS    = 8,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clock,
    input  logic                    reset_L,
    input  logic [6:0]              segment,
    input  logic [NUM_DIGITS-1:0]   digit_sel_L,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic [NUM_DIGITS-1:0]   blank_out,
    output logic [NUM_DIGITS-1:0]   invalid_out,
    output logic                    update,
    output logic [3:0]              update_idx,
    output logic                    multi_sel_err
);

    localparam int SW = NUM_DIGITS + 7;
    localparam logic [7:0] LAST_COUNT = 8'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_COUNT = 2'd0,
        ST_EVAL  = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    logic [SW-1:0]         sync1;
    logic [SW-1:0]         sync2;
    logic [SW-1:0]         prev;
    logic                  same;
    logic [7:0]            count;
    logic [7:0]            count_next;
    state_t                state;
    state_t                state_next;

    logic [NUM_DIGITS-1:0] sel_low;
    logic [6:0]            seg_s;
    logic                  sel_multi;
    logic                  sel_one;
    logic [3:0]            sel_idx;
    logic [3:0]            dec_bcd;
    logic                  dec_blank;
    logic                  dec_invalid;
    logic                  stored_match;
    logic                  commit;
    logic                  pulse;
    logic                  multi_set;

    // Segment patterns are active-low: bit set means segment dark.
    function automatic logic [5:0] decode(input logic [6:0] s);
        logic [5:0] r;
        case (s)
            7'h40:   r = {4'd0, 2'b00};
            7'h79:   r = {4'd1, 2'b00};
            7'h24:   r = {4'd2, 2'b00};
            7'h30:   r = {4'd3, 2'b00};
            7'h19:   r = {4'd4, 2'b00};
            7'h12:   r = {4'd5, 2'b00};
            7'h02:   r = {4'd6, 2'b00};
            7'h78:   r = {4'd7, 2'b00};
            7'h00:   r = {4'd8, 2'b00};
            7'h18:   r = {4'd9, 2'b00};
            7'h7F:   r = {4'd0, 2'b10};
            default: r = {4'hF, 2'b01};
        endcase
        return r;
    endfunction

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            sync1 <= '1;
            sync2 <= '1;
            prev  <= '1;
        end else begin
            sync1 <= {digit_sel_L, segment};
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign same = (sync2 == prev);

    always_comb begin
        count_next = 8'd0;
        if (same) begin
            count_next = (count == 8'hFF) ? count : count + 8'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            count <= 8'd0;
            state <= ST_COUNT;
        end else begin
            count <= count_next;
            state <= state_next;
        end
    end

    // EVAL is entered on the edge where the count reaches its target so the write lands one edge later.
    always_comb begin
        state_next = state;
        if (!same) begin
            state_next = ST_COUNT;
        end else begin
            case (state)
                ST_COUNT: if (count_next >= LAST_COUNT) state_next = ST_EVAL;
                ST_EVAL:  state_next = ST_HOLD;
                ST_HOLD:  state_next = ST_HOLD;
                default:  state_next = ST_COUNT;
            endcase
        end
    end

    always_comb begin
        sel_low   = ~sync2[SW-1:7];
        seg_s     = sync2[6:0];
        sel_multi = |(sel_low & (sel_low - 1'b1));
        sel_one   = (sel_low != '0) && !sel_multi;
        sel_idx   = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sel_low[i]) sel_idx = 4'(i);
        end
        {dec_bcd, dec_blank, dec_invalid} = decode(seg_s);
        stored_match = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sel_low[i]) begin
                stored_match = (bcd_out[4*i +: 4] == dec_bcd) &&
                               (blank_out[i] == dec_blank) &&
                               (invalid_out[i] == dec_invalid);
            end
        end
        commit    = (state == ST_EVAL) && same && sel_one;
        multi_set = (state == ST_EVAL) && same && sel_multi;
`ifdef SEG_CAPTURE_CHANGE_ONLY_EN
        pulse     = commit && !stored_match;
`else
        pulse     = commit;
`endif
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            bcd_out       <= '0;
            blank_out     <= '1;
            invalid_out   <= '0;
            update        <= 1'b0;
            update_idx    <= 4'd0;
            multi_sel_err <= 1'b0;
        end else begin
            update <= pulse;
            if (pulse) update_idx <= sel_idx;
            if (multi_set) multi_sel_err <= 1'b1;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (commit && sel_low[i]) begin
                    bcd_out[4*i +: 4] <= dec_bcd;
                    blank_out[i]      <= dec_blank;
                    invalid_out[i]    <= dec_invalid;
                end
            end
        end
    end

endmodule

// File: tb/tb_seven_segment_capture.sv
// tb/tb_seven_segment_capture.sv - scoreboard bench for seven_segment_capture
module tb_seven_segment_capture;

    logic        clock = 1'b0;
    logic        reset_L = 1'b0;
    logic [6:0]  segment = 7'h7F;
    logic [7:0]  digit_sel_L = 8'hFF;
    logic [31:0] bcd_out;
    logic [7:0]  blank_out;
    logic [7:0]  invalid_out;
    logic        update;
    logic [3:0]  update_idx;
    logic        multi_sel_err;

    typedef struct {
        logic [3:0] idx;
        logic [3:0] bcd;
        logic       blank;
        logic       invalid;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   update_count = 0;
    int   push_count = 0;
    int   mark;
    logic [6:0] codes [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h18};

    seven_segment_capture #(.NUM_DIGITS(8), .STABLE_CYCLES(4)) dut (
        .clock        (clock),
        .reset_L      (reset_L),
        .segment      (segment),
        .digit_sel_L  (digit_sel_L),
        .bcd_out      (bcd_out),
        .blank_out    (blank_out),
        .invalid_out  (invalid_out),
        .update       (update),
        .update_idx   (update_idx),
        .multi_sel_err(multi_sel_err)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (reset_L && update) begin
            update_count++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_update: got idx=%0d, required no update", update_idx);
            end else begin
                mon_e = exp_q.pop_front();
                if (update_idx !== mon_e.idx || bcd_out[4*mon_e.idx +: 4] !== mon_e.bcd ||
                    blank_out[mon_e.idx] !== mon_e.blank || invalid_out[mon_e.idx] !== mon_e.invalid) begin
                    errors++;
                    $display("FAIL update_value: got idx=%0d bcd=%h blank=%b inv=%b, required idx=%0d bcd=%h blank=%b inv=%b",
                             update_idx, bcd_out[4*mon_e.idx +: 4], blank_out[mon_e.idx], invalid_out[mon_e.idx],
                             mon_e.idx, mon_e.bcd, mon_e.blank, mon_e.invalid);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic push(input int idx, input logic [3:0] bcd, input logic blank, input logic inv);
        exp_t e;
        e.idx = 4'(idx);
        e.bcd = bcd;
        e.blank = blank;
        e.invalid = inv;
        exp_q.push_back(e);
        push_count++;
    endtask

    task automatic apply(input logic [7:0] sel, input logic [6:0] seg);
        @(posedge clock);
        #1;
        digit_sel_L = sel;
        segment = seg;
    endtask

    task automatic idle(input int n);
        apply(8'hFF, 7'h7F);
        repeat (n) @(posedge clock);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_bcd"}, bcd_out, 32'h0);
        check({tag, "_blank"}, {24'h0, blank_out}, 32'hFF);
        check({tag, "_invalid"}, {24'h0, invalid_out}, 32'h0);
        check({tag, "_update"}, {31'h0, update}, 32'h0);
        check({tag, "_multi"}, {31'h0, multi_sel_err}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_reset_values("reset");
        @(posedge clock);
        #1 reset_L = 1'b1;
        idle(10);

        // Single digit held: update after edge 6, one pulse only.
        mark = update_count;
        push(0, 4'd2, 1'b0, 1'b0);
        apply(8'hFE, 7'h24);
        repeat (6) @(posedge clock);
        @(negedge clock);
        check("no_update_edge5", {31'h0, update}, 32'h0);
        @(posedge clock);
        @(negedge clock);
        check("update_edge6", {31'h0, update}, 32'h1);
        repeat (15) @(posedge clock);
        check("single_pulse_held", update_count - mark, 1);
        check("digit0_bcd", {28'h0, bcd_out[3:0]}, 32'h2);
        idle(10);

        // Full scan 0..7, 6-cycle dwell.
        mark = update_count;
        for (int i = 0; i < 8; i++) begin
            push(i, 4'(i), 1'b0, 1'b0);
            apply(~(8'h01 << i), codes[i]);
            repeat (5) @(posedge clock);
        end
        idle(10);
        check("scan_updates", update_count - mark, 8);
        check("scan_bcd", bcd_out, 32'h7654_3210);
        check("scan_blank", {24'h0, blank_out}, 32'h0);

        // Blank then invalid on digit 3.
        push(3, 4'd0, 1'b1, 1'b0);
        apply(8'hF7, 7'h7F);
        repeat (10) @(posedge clock);
        check("d3_blank", {31'h0, blank_out[3]}, 32'h1);
        check("d3_blank_bcd", {28'h0, bcd_out[15:12]}, 32'h0);
        push(3, 4'hF, 1'b0, 1'b1);
        apply(8'hF7, 7'h55);
        repeat (10) @(posedge clock);
        check("d3_invalid", {31'h0, invalid_out[3]}, 32'h1);
        check("d3_invalid_bcd", {28'h0, bcd_out[15:12]}, 32'hF);
        check("d3_unblank", {31'h0, blank_out[3]}, 32'h0);
        idle(10);

        // Toggling every 3 cycles never commits.
        mark = update_count;
        for (int i = 0; i < 10; i++) begin
            apply(8'hFD, (i % 2) ? 7'h24 : 7'h79);
            repeat (2) @(posedge clock);
        end
        idle(10);
        check("toggle_no_update", update_count - mark, 0);

        // Two digits selected at once.
        mark = update_count;
        apply(8'hFC, 7'h24);
        repeat (12) @(posedge clock);
        check("multi_set", {31'h0, multi_sel_err}, 32'h1);
        check("multi_no_update", update_count - mark, 0);
        idle(10);
        check("multi_sticky", {31'h0, multi_sel_err}, 32'h1);

        // Same value re-scanned on digit 0 (currently 0).
        mark = update_count;
        for (int r = 0; r < 2; r++) begin
`ifndef SEG_CAPTURE_CHANGE_ONLY_EN
            push(0, 4'd0, 1'b0, 1'b0);
`endif
            apply(8'hFE, 7'h40);
            repeat (10) @(posedge clock);
            idle(10);
        end
`ifdef SEG_CAPTURE_CHANGE_ONLY_EN
        check("rescan_updates", update_count - mark, 0);
`else
        check("rescan_updates", update_count - mark, 2);
`endif

        // Reset mid-window discards the pending commit.
        mark = update_count;
        apply(8'hFE, 7'h19);
        repeat (3) @(posedge clock);
        #1;
        reset_L = 1'b0;
        digit_sel_L = 8'hFF;
        segment = 7'h7F;
        @(negedge clock);
        check_reset_values("midreset");
        repeat (2) @(posedge clock);
        #1 reset_L = 1'b1;
        repeat (15) @(posedge clock);
        @(negedge clock);
        check("midreset_no_update", update_count - mark, 0);
        check("post_reset_bcd", bcd_out, 32'h0);
        check("post_reset_blank", {24'h0, blank_out}, 32'hFF);

        check("queue_drained", exp_q.size(), 0);
        check("total_updates", update_count, push_count);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
